// File: rtl/switch_mcu_rf_arbiter_pkg.sv
// Shared defaults and types for the switch_mcu register-file arbiter.
// Optional macro SWITCH_MCU_RF_BYPASS_EN (see switch_mcu_rf_arbiter.sv).
package switch_mcu_rf_pkg;
  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned AW_DEF      = 5;
  localparam int unsigned DW_DEF      = 32;

  localparam logic [AW_DEF-1:0] REG_ZERO = '0;

  // Where a read port's returned data comes from in the final pipeline stage.
  typedef enum logic [1:0] {
    SRC_IDLE,
    SRC_RF,
    SRC_ZERO,
    SRC_BYP
  } rsrc_e;
endpackage

// File: rtl/switch_mcu_rf_arbiter_if.sv
// Bundles the requester-side and regfile-side signals of the register-file arbiter.
interface switch_mcu_rf_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 32
);
  logic [NUM_REQ-1:0]    in_req_ren;
  logic [NUM_REQ*AW-1:0] in_req_raddr_1;
  logic [NUM_REQ*AW-1:0] in_req_raddr_2;
  logic [NUM_REQ-1:0]    in_req_wen;
  logic [NUM_REQ*AW-1:0] in_req_waddr;
  logic [NUM_REQ*DW-1:0] in_req_wdata;
  logic [NUM_REQ-1:0]    out_gnt_r;
  logic [NUM_REQ-1:0]    out_gnt_w;
  logic [NUM_REQ-1:0]    out_rvalid;
  logic [DW-1:0]         out_rdata_1;
  logic [DW-1:0]         out_rdata_2;
  logic                  out_rf_ren;
  logic [AW-1:0]         out_rf_raddr_1;
  logic [AW-1:0]         out_rf_raddr_2;
  logic [DW-1:0]         in_rf_rdata_1;
  logic [DW-1:0]         in_rf_rdata_2;
  logic                  out_rf_wen;
  logic [AW-1:0]         out_rf_waddr;
  logic [DW-1:0]         out_rf_wdata;

  modport slave (
    input  in_req_ren, in_req_raddr_1, in_req_raddr_2,
    input  in_req_wen, in_req_waddr, in_req_wdata,
    input  in_rf_rdata_1, in_rf_rdata_2,
    output out_gnt_r, out_gnt_w, out_rvalid, out_rdata_1, out_rdata_2,
    output out_rf_ren, out_rf_raddr_1, out_rf_raddr_2,
    output out_rf_wen, out_rf_waddr, out_rf_wdata
  );

  modport master (
    output in_req_ren, in_req_raddr_1, in_req_raddr_2,
    output in_req_wen, in_req_waddr, in_req_wdata,
    output in_rf_rdata_1, in_rf_rdata_2,
    input  out_gnt_r, out_gnt_w, out_rvalid, out_rdata_1, out_rdata_2,
    input  out_rf_ren, out_rf_raddr_1, out_rf_raddr_2,
    input  out_rf_wen, out_rf_waddr, out_rf_wdata
  );
endinterface

// File: rtl/switch_mcu_rf_arbiter_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, search starts at the pointer,
// pointer moves one past the winner.
module switch_mcu_rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic         in_clk,
  input  logic         in_rst,
  input  logic [N-1:0] in_req,
  output logic [N-1:0] out_gnt
);
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] idx;
  logic          hit;

  always_comb begin
    out_gnt = '0;
    ptr_nxt = ptr;
    idx     = '0;
    hit     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!in_rst && !hit && in_req[idx]) begin
        hit          = 1'b1;
        out_gnt[idx] = 1'b1;
        ptr_nxt      = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) ptr <= '0;
    else        ptr <= ptr_nxt;
  end
endmodule

// File: rtl/switch_mcu_rf_arbiter.sv
// Shares regfile read ports 1/2 and the write port among NUM_REQ ex units.
// Define SWITCH_MCU_RF_BYPASS_EN to forward a same-time write into the read return.
module switch_mcu_rf_arbiter
  import switch_mcu_rf_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF
) (
  input logic                    in_clk,
  input logic                    in_rst,
  switch_mcu_rf_arbiter_if.slave bus
);
  logic [NUM_REQ-1:0] gnt_r, gnt_w;
  logic [AW-1:0]      sel_ra_1, sel_ra_2, sel_wa;
  logic [DW-1:0]      sel_wd;
  logic               w_ok;

  logic               s1_ren;
  logic [NUM_REQ-1:0] s1_owner;
  logic [AW-1:0]      s1_ra_1, s1_ra_2;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;

  logic [NUM_REQ-1:0] s2_owner;
  rsrc_e              s2_src_1, s2_src_2;
  logic [DW-1:0]      s2_byp_data;
  logic               byp_1, byp_2;

  function automatic rsrc_e src_sel(input logic ren, input logic zero, input logic byp);
    if (!ren) return SRC_IDLE;
    if (zero) return SRC_ZERO;
    if (byp)  return SRC_BYP;
    return SRC_RF;
  endfunction

  switch_mcu_rr_arb #(.N(NUM_REQ)) u_arb_r (
    .in_clk  (in_clk),
    .in_rst  (in_rst),
    .in_req  (bus.in_req_ren),
    .out_gnt (gnt_r)
  );

  switch_mcu_rr_arb #(.N(NUM_REQ)) u_arb_w (
    .in_clk  (in_clk),
    .in_rst  (in_rst),
    .in_req  (bus.in_req_wen),
    .out_gnt (gnt_w)
  );

  // Grants are one-hot, so an OR of masked slices is the selected requester's field.
  always_comb begin
    sel_ra_1 = '0;
    sel_ra_2 = '0;
    sel_wa   = '0;
    sel_wd   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_r[i]) begin
        sel_ra_1 = sel_ra_1 | bus.in_req_raddr_1[i*AW +: AW];
        sel_ra_2 = sel_ra_2 | bus.in_req_raddr_2[i*AW +: AW];
      end
      if (gnt_w[i]) begin
        sel_wa = sel_wa | bus.in_req_waddr[i*AW +: AW];
        sel_wd = sel_wd | bus.in_req_wdata[i*DW +: DW];
      end
    end
  end

  assign w_ok = (|gnt_w) && (sel_wa != AW'(REG_ZERO));

`ifdef SWITCH_MCU_RF_BYPASS_EN
  assign byp_1 = wr_en && (wr_addr == s1_ra_1);
  assign byp_2 = wr_en && (wr_addr == s1_ra_2);
`else
  assign byp_1 = 1'b0;
  assign byp_2 = 1'b0;
`endif

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      s1_ren      <= 1'b0;
      s1_owner    <= '0;
      s1_ra_1     <= '0;
      s1_ra_2     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      s2_owner    <= '0;
      s2_src_1    <= SRC_IDLE;
      s2_src_2    <= SRC_IDLE;
      s2_byp_data <= '0;
    end else begin
      s1_ren      <= |gnt_r;
      s1_owner    <= gnt_r;
      s1_ra_1     <= sel_ra_1;
      s1_ra_2     <= sel_ra_2;
      wr_en       <= w_ok;
      wr_addr     <= w_ok ? sel_wa : '0;
      wr_data     <= w_ok ? sel_wd : '0;
      s2_owner    <= s1_owner;
      s2_src_1    <= src_sel(s1_ren, s1_ra_1 == AW'(REG_ZERO), byp_1);
      s2_src_2    <= src_sel(s1_ren, s1_ra_2 == AW'(REG_ZERO), byp_2);
      s2_byp_data <= wr_data;
    end
  end

  // The regfile answers one cycle after out_rf_ren, so the return mux sits after the stage-2 flops.
  always_comb begin
    case (s2_src_1)
      SRC_RF:  bus.out_rdata_1 = bus.in_rf_rdata_1;
      SRC_BYP: bus.out_rdata_1 = s2_byp_data;
      default: bus.out_rdata_1 = '0;
    endcase
    case (s2_src_2)
      SRC_RF:  bus.out_rdata_2 = bus.in_rf_rdata_2;
      SRC_BYP: bus.out_rdata_2 = s2_byp_data;
      default: bus.out_rdata_2 = '0;
    endcase
  end

  assign bus.out_gnt_r      = gnt_r;
  assign bus.out_gnt_w      = gnt_w;
  assign bus.out_rvalid     = s2_owner;
  assign bus.out_rf_ren     = s1_ren;
  assign bus.out_rf_raddr_1 = s1_ra_1;
  assign bus.out_rf_raddr_2 = s1_ra_2;
  assign bus.out_rf_wen     = wr_en;
  assign bus.out_rf_waddr   = wr_addr;
  assign bus.out_rf_wdata   = wr_data;
endmodule
